// File: rtl/eq_volume_limiter.sv
`default_nettype none
// ============================================================================
// Module   : eq_volume_limiter
// Brief    : EQ output stage. Applies a programmable signed per-channel
//            volume gain (one multiplier shared between L and R), rounds
//            half-up, saturates back to DATA_W bits, counts clip events and
//            strobes the scaled pair to the output formatter.
//            Optional peak meter enabled by defining EQ_VOL_PEAK_METER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module eq_volume_limiter #(
    parameter int DATA_W    = 24,
    parameter int GAIN_W    = 16,
    parameter int GAIN_FRAC = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              vol_wr,
    input  logic              vol_sel,
    input  logic [7:0]        vol_lsb,
    input  logic [7:0]        vol_msb,
    input  logic              clip_clr,
    input  logic              l_data_en,
    input  logic              r_data_en,
    input  logic [DATA_W-1:0] l_data_in,
    input  logic [DATA_W-1:0] r_data_in,
    output logic              l_data_valid,
    output logic              r_data_valid,
    output logic [DATA_W-1:0] l_data_out,
    output logic [DATA_W-1:0] r_data_out,
    output logic [15:0]       clip_count,
    output logic              overrun,
    output logic              busy,
    output logic [DATA_W-2:0] l_peak,
    output logic [DATA_W-2:0] r_peak
);

    localparam int PROD_W = DATA_W + GAIN_W;

    localparam logic [GAIN_W-1:0] c_unity =
        {{(GAIN_W-GAIN_FRAC-1){1'b0}}, 1'b1, {GAIN_FRAC{1'b0}}};
    localparam logic [PROD_W-1:0] c_round =
        {{(PROD_W-GAIN_FRAC){1'b0}}, 1'b1, {(GAIN_FRAC-1){1'b0}}};
    localparam logic signed [PROD_W-1:0] c_pos_lim =
        {{(PROD_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] c_neg_lim =
        {{(PROD_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] c_out_max = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] c_out_min = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUL_L = 2'd1,
        S_MUL_R = 2'd2,
        S_SAT   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [GAIN_W-1:0]   stage_l_q, stage_l_d, stage_r_q, stage_r_d;
    logic [GAIN_W-1:0]   gain_l_q, gain_l_d, gain_r_q, gain_r_d;
    logic [DATA_W-1:0]   l_in_q, l_in_d, r_in_q, r_in_d;
    logic [PROD_W-1:0]   prod_l_q, prod_l_d, prod_r_q, prod_r_d;
    logic [DATA_W-1:0]   l_out_q, l_out_d, r_out_q, r_out_d;
    logic                valid_q, valid_d;
    logic [15:0]         clip_cnt_q, clip_cnt_d;
    logic                overrun_q, overrun_d;

    logic                w_strobe;
    logic [GAIN_W-1:0]   w_vol_word;
    logic [DATA_W-1:0]   w_mul_a;
    logic [GAIN_W-1:0]   w_mul_b;
    logic [PROD_W-1:0]   w_prod;
    logic [DATA_W:0]     w_l_rs, w_r_rs;
    logic [1:0]          w_clip_add;
    logic [16:0]         w_clip_sum;

    // Round half up, then clamp to the signed DATA_W range; MSB flags a clip.
    function automatic logic [DATA_W:0] round_sat(input logic [PROD_W-1:0] prod);
        logic signed [PROD_W-1:0] shifted;
        shifted = $signed(prod + c_round) >>> GAIN_FRAC;
        if (shifted > c_pos_lim)
            round_sat = {1'b1, c_out_max};
        else if (shifted < c_neg_lim)
            round_sat = {1'b1, c_out_min};
        else
            round_sat = {1'b0, shifted[DATA_W-1:0]};
    endfunction

    assign w_strobe   = l_data_en | r_data_en;
    assign w_vol_word = {vol_msb, vol_lsb};

    // Single shared multiplier: left operands except in the MUL_R state.
    // Operands are sign-extended so the truncated product is exact.
    assign w_mul_a = (state_q == S_MUL_R) ? r_in_q   : l_in_q;
    assign w_mul_b = (state_q == S_MUL_R) ? gain_r_q : gain_l_q;
    assign w_prod  = {{GAIN_W{w_mul_a[DATA_W-1]}}, w_mul_a} *
                     {{DATA_W{w_mul_b[GAIN_W-1]}}, w_mul_b};

    assign w_l_rs     = round_sat(prod_l_q);
    assign w_r_rs     = round_sat(prod_r_q);
    assign w_clip_add = {1'b0, w_l_rs[DATA_W]} + {1'b0, w_r_rs[DATA_W]};
    assign w_clip_sum = {1'b0, clip_cnt_q} + {15'd0, w_clip_add};

    // Gain staging: active gains follow staging only while idle with no strobe,
    // so a sample in flight never sees a gain change.
    always_comb begin
        stage_l_d = stage_l_q;
        stage_r_d = stage_r_q;
        gain_l_d  = gain_l_q;
        gain_r_d  = gain_r_q;
        if (vol_wr) begin
            if (vol_sel)
                stage_r_d = w_vol_word;
            else
                stage_l_d = w_vol_word;
        end
        if ((state_q == S_IDLE) && !w_strobe) begin
            gain_l_d = stage_l_q;
            gain_r_d = stage_r_q;
        end
    end

    // Sequencer and datapath: capture, multiply L, multiply R, saturate/emit.
    always_comb begin
        state_d    = state_q;
        l_in_d     = l_in_q;
        r_in_d     = r_in_q;
        prod_l_d   = prod_l_q;
        prod_r_d   = prod_r_q;
        l_out_d    = l_out_q;
        r_out_d    = r_out_q;
        valid_d    = 1'b0;
        clip_cnt_d = clip_cnt_q;
        overrun_d  = overrun_q;

        case (state_q)
            S_IDLE: begin
                if (w_strobe && run) begin
                    state_d = S_MUL_L;
                    l_in_d  = l_data_in;
                    r_in_d  = r_data_in;
                end
            end
            S_MUL_L: begin
                if (run) begin
                    prod_l_d = w_prod;
                    state_d  = S_MUL_R;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_MUL_R: begin
                if (run) begin
                    prod_r_d = w_prod;
                    state_d  = S_SAT;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_SAT: begin
                state_d = S_IDLE;
                if (run) begin
                    valid_d    = 1'b1;
                    l_out_d    = w_l_rs[DATA_W-1:0];
                    r_out_d    = w_r_rs[DATA_W-1:0];
                    clip_cnt_d = w_clip_sum[16] ? 16'hFFFF : w_clip_sum[15:0];
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A strobe arriving mid-sequence is dropped and flagged.
        if (w_strobe && (state_q != S_IDLE))
            overrun_d = 1'b1;

        // Clear has priority over a same-cycle clip or overrun.
        if (clip_clr) begin
            clip_cnt_d = 16'd0;
            overrun_d  = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            stage_l_q  <= c_unity;
            stage_r_q  <= c_unity;
            gain_l_q   <= c_unity;
            gain_r_q   <= c_unity;
            l_in_q     <= '0;
            r_in_q     <= '0;
            prod_l_q   <= '0;
            prod_r_q   <= '0;
            l_out_q    <= '0;
            r_out_q    <= '0;
            valid_q    <= 1'b0;
            clip_cnt_q <= 16'd0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            stage_l_q  <= stage_l_d;
            stage_r_q  <= stage_r_d;
            gain_l_q   <= gain_l_d;
            gain_r_q   <= gain_r_d;
            l_in_q     <= l_in_d;
            r_in_q     <= r_in_d;
            prod_l_q   <= prod_l_d;
            prod_r_q   <= prod_r_d;
            l_out_q    <= l_out_d;
            r_out_q    <= r_out_d;
            valid_q    <= valid_d;
            clip_cnt_q <= clip_cnt_d;
            overrun_q  <= overrun_d;
        end
    end

    assign l_data_valid = valid_q;
    assign r_data_valid = valid_q;
    assign l_data_out   = l_out_q;
    assign r_data_out   = r_out_q;
    assign clip_count   = clip_cnt_q;
    assign overrun      = overrun_q;
    assign busy         = (state_q != S_IDLE);

`ifdef EQ_VOL_PEAK_METER_EN
    logic [DATA_W-2:0] l_peak_q, l_peak_d, r_peak_q, r_peak_d;
    logic [DATA_W-2:0] w_l_mag, w_r_mag;

    // Magnitude of a saturated sample; the most negative code maps to max.
    function automatic logic [DATA_W-2:0] mag(input logic [DATA_W-1:0] s);
        if (!s[DATA_W-1])
            mag = s[DATA_W-2:0];
        else if (s == c_out_min)
            mag = '1;
        else
            mag = ~s[DATA_W-2:0] + {{(DATA_W-2){1'b0}}, 1'b1};
    endfunction

    assign w_l_mag = mag(w_l_rs[DATA_W-1:0]);
    assign w_r_mag = mag(w_r_rs[DATA_W-1:0]);

    // Peak hold: track the largest emitted magnitude until cleared.
    always_comb begin
        l_peak_d = l_peak_q;
        r_peak_d = r_peak_q;
        if ((state_q == S_SAT) && run) begin
            if (w_l_mag > l_peak_q)
                l_peak_d = w_l_mag;
            if (w_r_mag > r_peak_q)
                r_peak_d = w_r_mag;
        end
        if (clip_clr) begin
            l_peak_d = '0;
            r_peak_d = '0;
        end
    end

    // Peak registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l_peak_q <= '0;
            r_peak_q <= '0;
        end else begin
            l_peak_q <= l_peak_d;
            r_peak_q <= r_peak_d;
        end
    end

    assign l_peak = l_peak_q;
    assign r_peak = r_peak_q;
`else
    assign l_peak = '0;
    assign r_peak = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_eq_volume_limiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_eq_volume_limiter
// Brief    : Self-checking bench for eq_volume_limiter: directed vectors plus
//            randomized gain/sample pairs against an arithmetic model.
//            Peak expectations follow EQ_VOL_PEAK_METER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eq_volume_limiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        vol_wr;
    logic        vol_sel;
    logic [7:0]  vol_lsb;
    logic [7:0]  vol_msb;
    logic        clip_clr;
    logic        l_data_en;
    logic        r_data_en;
    logic [23:0] l_data_in;
    logic [23:0] r_data_in;
    logic        l_data_valid;
    logic        r_data_valid;
    logic [23:0] l_data_out;
    logic [23:0] r_data_out;
    logic [15:0] clip_count;
    logic        overrun;
    logic        busy;
    logic [22:0] l_peak;
    logic [22:0] r_peak;

    int checks = 0;
    int errors = 0;

    // Model state: gains in effect, staged gains, clip counter, peaks, last outputs.
    logic [15:0] m_gain_l, m_gain_r, m_stage_l, m_stage_r;
    int          m_clip;
    logic [22:0] m_peak_l, m_peak_r;
    logic [23:0] m_last_l, m_last_r;

    eq_volume_limiter dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .vol_wr       (vol_wr),
        .vol_sel      (vol_sel),
        .vol_lsb      (vol_lsb),
        .vol_msb      (vol_msb),
        .clip_clr     (clip_clr),
        .l_data_en    (l_data_en),
        .r_data_en    (r_data_en),
        .l_data_in    (l_data_in),
        .r_data_in    (r_data_in),
        .l_data_valid (l_data_valid),
        .r_data_valid (r_data_valid),
        .l_data_out   (l_data_out),
        .r_data_out   (r_data_out),
        .clip_count   (clip_count),
        .overrun      (overrun),
        .busy         (busy),
        .l_peak       (l_peak),
        .r_peak       (r_peak)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scaled sample: x * g / 2^14 rounded half up (floor of +0.5), clamped to 24 bits.
    function automatic logic [23:0] scale(input logic [23:0] x, input logic [15:0] g,
                                          output bit clipped);
        longint p;
        longint q;
        logic [23:0] res;
        p = longint'($signed(x)) * longint'($signed(g));
        q = (p + 64'sd8192) >>> 14;
        clipped = 1'b0;
        if (q > 64'sd8388607) begin
            clipped = 1'b1;
            res = 24'h7FFFFF;
        end else if (q < -64'sd8388608) begin
            clipped = 1'b1;
            res = 24'h800000;
        end else begin
            res = q[23:0];
        end
        return res;
    endfunction

    function automatic logic [22:0] magnitude(input logic [23:0] v);
        int s;
        s = $signed(v);
        if (s < 0) s = -s;
        if (s > 8388607) s = 8388607;
        return s[22:0];
    endfunction

    function automatic logic [22:0] exp_peak(input logic [22:0] p);
`ifdef EQ_VOL_PEAK_METER_EN
        return p;
`else
        return (p & 23'd0);
`endif
    endfunction

    task automatic model_clear();
        m_clip   = 0;
        m_peak_l = '0;
        m_peak_r = '0;
    endtask

    task automatic write_gain(input bit sel, input logic [15:0] g);
        vol_wr  = 1'b1;
        vol_sel = sel;
        vol_msb = g[15:8];
        vol_lsb = g[7:0];
        tick();
        vol_wr  = 1'b0;
        tick();
        if (sel) m_stage_r = g; else m_stage_l = g;
        m_gain_l = m_stage_l;
        m_gain_r = m_stage_r;
    endtask

    task automatic do_clip_clr();
        clip_clr = 1'b1;
        tick();
        clip_clr = 1'b0;
        model_clear();
    endtask

    // One sample pair through the stage, optionally with a same-cycle gain write.
    task automatic run_pair(input string tag, input logic [23:0] l, input logic [23:0] r,
                            input bit wr, input bit sel, input logic [15:0] g);
        logic [23:0] el, er;
        bit cl, cr;
        int n;
        el = scale(l, m_gain_l, cl);
        er = scale(r, m_gain_r, cr);
        l_data_en = 1'b1;
        r_data_en = 1'b1;
        l_data_in = l;
        r_data_in = r;
        if (wr) begin
            vol_wr  = 1'b1;
            vol_sel = sel;
            vol_msb = g[15:8];
            vol_lsb = g[7:0];
        end
        tick();
        l_data_en = 1'b0;
        r_data_en = 1'b0;
        vol_wr    = 1'b0;
        if (wr) begin
            if (sel) m_stage_r = g; else m_stage_l = g;
        end
        check({tag, "_busy"}, busy, 1);
        n = 0;
        while (!l_data_valid && n < 8) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 3);
        check({tag, "_r_valid"}, r_data_valid, 1);
        check({tag, "_l_out"}, l_data_out, el);
        check({tag, "_r_out"}, r_data_out, er);
        m_clip = m_clip + int'(cl) + int'(cr);
        if (m_clip > 65535) m_clip = 65535;
        if (magnitude(el) > m_peak_l) m_peak_l = magnitude(el);
        if (magnitude(er) > m_peak_r) m_peak_r = magnitude(er);
        m_last_l = el;
        m_last_r = er;
        check({tag, "_clip_count"}, clip_count, m_clip);
        check({tag, "_l_peak"}, l_peak, exp_peak(m_peak_l));
        check({tag, "_r_peak"}, r_peak, exp_peak(m_peak_r));
        tick();
        check({tag, "_valid_one_cycle"}, l_data_valid, 0);
        check({tag, "_idle"}, busy, 0);
        m_gain_l = m_stage_l;
        m_gain_r = m_stage_r;
    endtask

    initial begin
        logic [31:0] rnd;
        logic [15:0] gl, gr;
        logic [23:0] el;
        bit          cl;
        int          pulses;
        logic [15:0] gain_pool [5];

        gain_pool[0] = 16'h4000; gain_pool[1] = 16'h7FFF; gain_pool[2] = 16'h8000;
        gain_pool[3] = 16'h0000; gain_pool[4] = 16'hC000;

        reset = 1'b1; run = 1'b1; vol_wr = 1'b0; vol_sel = 1'b0;
        vol_lsb = 8'h00; vol_msb = 8'h00; clip_clr = 1'b0;
        l_data_en = 1'b0; r_data_en = 1'b0; l_data_in = '0; r_data_in = '0;
        m_gain_l = 16'h4000; m_gain_r = 16'h4000;
        m_stage_l = 16'h4000; m_stage_r = 16'h4000;
        m_last_l = '0; m_last_r = '0;
        model_clear();

        // Reset state
        tick(); tick();
        check("rst_l_valid", l_data_valid, 0);
        check("rst_r_valid", r_data_valid, 0);
        check("rst_l_out", l_data_out, 0);
        check("rst_r_out", r_data_out, 0);
        check("rst_clip", clip_count, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        check("rst_l_peak", l_peak, 0);
        check("rst_r_peak", r_peak, 0);
        reset = 1'b0;
        tick();

        // Unity default gains pass samples unchanged
        run_pair("unity", 24'h100000, 24'hF00000, 0, 0, 16'h0);
        check("unity_l_const", l_data_out, 24'h100000);
        check("unity_r_const", r_data_out, 24'hF00000);

        // Half and minus-one gains, rounding
        write_gain(0, 16'h2000);
        write_gain(1, 16'hC000);
        run_pair("halfneg", 24'h000003, 24'h400000, 0, 0, 16'h0);
        check("halfneg_l_const", l_data_out, 24'h000002);
        check("halfneg_r_const", r_data_out, 24'hC00000);

        // Saturation on both channels, then clear
        write_gain(0, 16'h7FFF);
        write_gain(1, 16'h7FFF);
        run_pair("sat", 24'h7FFFFF, 24'h800000, 0, 0, 16'h0);
        check("sat_l_const", l_data_out, 24'h7FFFFF);
        check("sat_r_const", r_data_out, 24'h800000);
        check("sat_clip_const", clip_count, 2);
        do_clip_clr();
        check("clr_clip", clip_count, 0);
        check("clr_l_peak", l_peak, 0);

        // Gain write coinciding with a strobe applies to the next sample only
        write_gain(0, 16'h4000);
        write_gain(1, 16'h4000);
        run_pair("coinc1", 24'h100000, 24'h000000, 1, 0, 16'h2000);
        check("coinc1_const", l_data_out, 24'h100000);
        run_pair("coinc2", 24'h100000, 24'h000000, 0, 0, 16'h0);
        check("coinc2_const", l_data_out, 24'h080000);

        // Strobe while busy is dropped and flags overrun
        el = scale(24'h000123, m_gain_l, cl);
        l_data_en = 1'b1; r_data_en = 1'b1;
        l_data_in = 24'h000123; r_data_in = 24'h000456;
        tick();
        l_data_en = 1'b0; r_data_en = 1'b0;
        tick();
        l_data_en = 1'b1; r_data_en = 1'b1;
        l_data_in = 24'h7FFFFF; r_data_in = 24'h7FFFFF;
        tick();
        l_data_en = 1'b0; r_data_en = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (l_data_valid) pulses++;
        end
        check("ovr_pulses", pulses, 1);
        check("ovr_flag", overrun, 1);
        check("ovr_l_out", l_data_out, el);
        check("ovr_busy", busy, 0);
        m_last_l = el;
        m_last_r = scale(24'h000456, m_gain_r, cl);
        do_clip_clr();
        check("ovr_cleared", overrun, 0);

        // Run dropped during MUL_R aborts the sample
        l_data_en = 1'b1; r_data_en = 1'b1;
        l_data_in = 24'h300000; r_data_in = 24'h200000;
        tick();
        l_data_en = 1'b0; r_data_en = 1'b0;
        tick();
        run = 1'b0;
        tick();
        check("runlow_busy", busy, 0);
        check("runlow_valid", l_data_valid, 0);
        run = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (l_data_valid) pulses++;
        end
        check("runlow_no_pulse", pulses, 0);
        check("runlow_l_hold", l_data_out, m_last_l);
        check("runlow_r_hold", r_data_out, m_last_r);

        // Asynchronous reset mid-operation
        write_gain(0, 16'h2000);
        l_data_en = 1'b1; r_data_en = 1'b1;
        l_data_in = 24'h7FFFFF; r_data_in = 24'h7FFFFF;
        tick();
        l_data_en = 1'b0; r_data_en = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_l_out", l_data_out, 0);
        reset = 1'b0;
        m_gain_l = 16'h4000; m_gain_r = 16'h4000;
        m_stage_l = 16'h4000; m_stage_r = 16'h4000;
        model_clear();
        tick(); tick();
        run_pair("post_rst", 24'h234567, 24'hFEDCBA, 0, 0, 16'h0);

        // Peak meter
        do_clip_clr();
        run_pair("peak1", 24'h123456, 24'h000100, 0, 0, 16'h0);
        check("peak1_const", l_peak, exp_peak(23'h123456));
        run_pair("peak2", 24'hF00000, 24'h000010, 0, 0, 16'h0);
        check("peak2_const", l_peak, exp_peak(23'h123456));
        do_clip_clr();
        check("peak_clr_l", l_peak, 0);
        check("peak_clr_r", r_peak, 0);

        // Randomized gains and samples against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            rnd = $urandom;
            gl = (rnd[1:0] == 2'd0) ? gain_pool[$urandom_range(0, 4)] : rnd[31:16];
            rnd = $urandom;
            gr = (rnd[1:0] == 2'd0) ? gain_pool[$urandom_range(0, 4)] : rnd[31:16];
            write_gain(0, gl);
            write_gain(1, gr);
            rnd = $urandom;
            el = rnd[23:0];
            rnd = $urandom;
            run_pair("rand", el, rnd[23:0], 0, 0, 16'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eq_volume_limiter.md
Name: eq_volume_limiter

Overview:
- Output stage directly downstream of the equalizer gain/accumulate stage.
- Takes the truncated 24-bit left/right EQ sums and their valid strobes, and applies a CPU-programmed per-channel volume gain using one time-shared multiplier.
- Rounds and saturates the result back to 24 bits, counts clip events, and presents strobed samples to the output formatter.

Parameters:
- DATA_W, 24, sample width in and out (signed two's complement).
- GAIN_W, 16, volume gain width (signed).
- GAIN_FRAC, 14, fractional bits of gain; unity = 1 << GAIN_FRAC (0x4000).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  stage enable; low forces FSM to IDLE.
- vol_wr  in  1  single-cycle write strobe for staging gain.
- vol_sel  in  1  0 = left staging gain, 1 = right staging gain.
- vol_lsb  in  8  gain low byte.
- vol_msb  in  8  gain high byte.
- clip_clr  in  1  clears clip_count and overrun.
- l_data_en  in  1  left input strobe (asserted together with r_data_en).
- r_data_en  in  1  right input strobe.
- l_data_in  in  DATA_W  left sample.
- r_data_in  in  DATA_W  right sample.
- l_data_valid  out  1  left output strobe.
- r_data_valid  out  1  right output strobe.
- l_data_out  out  DATA_W  left scaled sample.
- r_data_out  out  DATA_W  right scaled sample.
- clip_count  out  16  saturating count of clipped channel-samples.
- overrun  out  1  sticky: a strobe arrived while busy.
- busy  out  1  high when FSM is not IDLE.
- l_peak  out  DATA_W-1  left peak magnitude (optional feature).
- r_peak  out  DATA_W-1  right peak magnitude (optional feature).

Behaviour:
- Reset values: all outputs 0; staging and active gains = 0x4000; FSM = IDLE.
- Gain staging:
  - vol_wr writes {vol_msb, vol_lsb} into the staging register chosen by vol_sel.
  - Active gains load from staging only on cycles where the FSM is IDLE and (l_data_en | r_data_en) is low.
  - If vol_wr coincides with a strobe, that sample uses the old active gains.
- Start condition: FSM starts on (l_data_en | r_data_en) while IDLE and run is high. Both inputs are captured on that edge.
- FSM (one state per cycle):
  - IDLE -> MUL_L -> MUL_R -> SAT -> IDLE.
  - MUL_L registers prod_l = l_in * gain_l (signed 40-bit).
  - MUL_R registers prod_r using the same multiplier.
  - SAT registers both outputs and pulses l_data_valid and r_data_valid together for exactly 1 cycle.
- Latency: strobe at edge T -> valid high in cycle T+3.
- Throughput: one sample pair per 4 cycles. Back-to-back strobes at 4-cycle spacing are accepted.
- Arithmetic, per channel:
  - r = (prod + (1 << (GAIN_FRAC-1))) >>> GAIN_FRAC, arithmetic shift, round half up.
  - r > 2^23-1 -> 0x7FFFFF; r < -2^23 -> 0x800000; otherwise r[23:0].
- Clip counting:
  - clip_count += number of channels saturated in SAT (0, 1 or 2), saturating at 0xFFFF.
  - clip_clr in the same cycle as a clip: clear wins, count = 0.
- Overrun:
  - A strobe while busy is ignored and sets overrun.
  - overrun stays set until clip_clr or reset.
- run low mid-operation: FSM returns to IDLE next edge; no valid pulse; outputs hold last values.
- Reset mid-operation: immediate return to reset values.

Optional Feature:
- Macro EQ_VOL_PEAK_METER_EN.
- Defined:
  - l_peak/r_peak register the maximum |output| seen since the last clear.
  - |0x800000| is taken as 0x7FFFFF.
  - Updated in the SAT cycle; cleared by clip_clr or reset.
- Undefined: l_peak/r_peak tied to 0; no peak logic synthesised.

Test Plan:
- Reset, default gains; l_in = 0x100000, r_in = 0xF00000 strobe -> valid at T+3, l_out = 0x100000, r_out = 0xF00000, clip_count = 0.
- gain_l = 0x2000 (0.5), gain_r = 0xC000 (-1.0); l_in = 0x000003, r_in = 0x400000 -> l_out = 0x000002 (rounded), r_out = 0xC00000.
- gain_l = 0x7FFF; l_in = 0x7FFFFF, r_in = 0x800000 with gain_r = 0x7FFF -> l_out = 0x7FFFFF, r_out = 0x800000, clip_count = 2; then clip_clr -> 0.
- vol_wr (left, 0x2000) in same cycle as strobe, l_in = 0x100000 -> first output 0x100000; next sample 0x100000 -> 0x080000.
- Second strobe 2 cycles after first -> ignored, overrun = 1, exactly one valid pulse; run low during MUL_R -> no valid, busy = 0 next cycle.
- EQ_VOL_PEAK_METER_EN defined; outputs 0x123456, then 0xF00000 -> l_peak = 0x123456, then 0x123456 kept (|0xF00000| = 0x100000 is smaller); clip_clr -> 0.
